arc4_encrypt: RTL and testbench
===============================

Name: arc4_encrypt

Overview:
- Encrypting end of the lab's ARC4 datapath: reads a length-prefixed plaintext byte string from PT memory and writes a length-prefixed ciphertext string to CT memory.
- CT memory uses the same layout the decrypt task consumes.
- Owns the 256-byte S-box memory port; runs INIT, KSA and PRGA with a 24-bit key.
- Sits beside the decrypt task on the DE1 top level: key from SW, start from KEY, status on LEDR.

Parameters:
- KEY_W, 24, key width in bits; 3 key bytes, keylength = KEY_W/8.
- DROP_N, 256, keystream bytes discarded before encryption; used only when ARC4_DROP_EN is defined.

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  start request; sampled only while rdy=1.
- rdy  out  1  block idle and ready to accept en.
- key  in  KEY_W  encryption key; key[23:16] is key byte 0; latched at start.
- s_addr  out  8  S-memory address.
- s_wrdata  out  8  S-memory write data.
- s_wren  out  1  S-memory write enable.
- s_rddata  in  8  S-memory read data.
- pt_addr  out  8  plaintext address.
- pt_rddata  in  8  plaintext data.
- ct_addr  out  8  ciphertext address.
- ct_wrdata  out  8  ciphertext write data.
- ct_wren  out  1  ciphertext write enable.

Behaviour:
- Memory timing: all memories are synchronous, one-cycle read latency. Data is valid the cycle after the address is presented. Writes commit on the cycle ct_wren/s_wren is high.
- Reset (async): state=IDLE, rdy=1, all wren=0, all addresses/wrdata=0, internal i/j/k/len=0.
- IDLE: rdy=1. en=1 latches key and moves to INIT; rdy=0 from the next cycle. en while rdy=0 is ignored.
- INIT: write S[i]=i for i=0..255, one write per cycle (256 cycles).
- KSA, for i=0..255:
  - read S[i];
  - j = j + S[i] + key[i mod 3] (mod 256);
  - read S[j];
  - write S[i]=S[j], then S[j]=old S[i].
  - When i==j, both writes target the same address and the final value equals the original.
- LEN: read pt[0] as len; write ct[0]=len.
- PRGA: i=j=0. For k=1..len:
  - i=i+1;
  - read S[i]; j=j+S[i];
  - read S[j]; swap S[i] and S[j];
  - read S[(S[i]+S[j]) mod 256] as pad;
  - read pt[k]; write ct[k] = pt[k] ^ pad.
- All index arithmetic is 8-bit wrap-around; k never exceeds 255.
- len=0: no PRGA iterations; only ct[0]=0 is written.
- DONE: one cycle, then IDLE; rdy=1 again.
- Mid-operation reset: immediate return to IDLE. Partial S/CT contents are undefined; the next en restarts from INIT.
- At most one of s_wren and ct_wren asserted per cycle is not required, but each port is written at most once per cycle.

Optional Feature:
- Macro: ARC4_DROP_EN.
- Defined: after KSA and before LEN, run DROP_N PRGA iterations (S swaps performed, pad discarded, no CT writes). PRGA for the message continues from the resulting i/j (not reset to 0).
- Undefined: no drop phase; output is standard ARC4.

Decomposition:
- Package arc4_pkg:
  - typedef byte_t (logic [7:0]);
  - state enum {IDLE, INIT, KSA, DROP, LEN, PRGA, DONE};
  - constants SBOX_SIZE=256 and KEY_BYTES=3.
- One sub-module, arc4_ksa: performs INIT+KSA on the S port with its own en/rdy handshake.
- Top arc4_encrypt muxes the S port between arc4_ksa and the PRGA FSM.

Test Plan:
- key=24'h4B6579 ("Key"), pt = {9,"Plaintext"} -> ct = {09,BB,F3,16,E8,D9,40,AF,0A,D3}; rdy returns to 1.
- key=24'h000018, pt={0} -> ct[0]=00, no other CT writes, rdy=1 after DONE.
- Round trip: encrypt random 255-byte pt with key 24'h1A2B3C, copy ct into PT memory, run again -> ct equals original pt.
- en pulsed repeatedly while rdy=0 -> ignored; exactly one ciphertext produced, identical to a single-start run.
- rst_n low during PRGA -> rdy=1 and all wren=0 asynchronously; a restart with the same key gives the correct ciphertext.
- With ARC4_DROP_EN, DROP_N=256: compare against the reference model's RC4-drop256 output for the "Key"/"Plaintext" case -> byte-exact match.

Source files
------------

// File: rtl/arc4_encrypt_pkg.sv
// Shared types and constants for the ARC4 encrypt datapath.
// Optional keystream drop (RC4-dropN) is selected by the ARC4_DROP_EN macro.
package arc4_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {IDLE, INIT, KSA, DROP, LEN, PRGA, DONE} state_t;

  // Sub-steps of one keystream iteration; reads need a wait cycle behind the registered address.
  typedef enum logic [3:0] {
    S_ISSUE_I, S_WAIT_I, S_TAKE_I, S_WAIT_J, S_TAKE_J,
    S_WRITE_J, S_ISSUE_PAD, S_WAIT_PAD, S_EMIT
  } step_t;

  typedef enum logic [3:0] {
    K_IDLE, K_INIT, K_RD_I, K_WAIT_I, K_GET_I, K_WAIT_J, K_GET_J, K_SWAP_J
  } ksa_state_t;

  localparam int SBOX_SIZE = 256;
  localparam int KEY_BYTES = 3;

  function automatic byte_t key_byte(input logic [8*KEY_BYTES-1:0] key, input logic [1:0] idx);
    case (idx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  endfunction

endpackage

// File: rtl/arc4_encrypt_if.sv
// Start handshake, key and the three memory ports of the ARC4 encrypt block.
// master = requester/memory side, slave = arc4_encrypt.
interface arc4_encrypt_if #(parameter int KEY_W = 24);
  import arc4_pkg::*;

  logic             en;
  logic             rdy;
  logic [KEY_W-1:0] key;
  byte_t            s_addr;
  byte_t            s_wrdata;
  logic             s_wren;
  byte_t            s_rddata;
  byte_t            pt_addr;
  byte_t            pt_rddata;
  byte_t            ct_addr;
  byte_t            ct_wrdata;
  logic             ct_wren;

  modport master (
    output en, key, s_rddata, pt_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
  );

  modport slave (
    input  en, key, s_rddata, pt_rddata,
    output rdy, s_addr, s_wrdata, s_wren, pt_addr, ct_addr, ct_wrdata, ct_wren
  );

endinterface

// File: rtl/arc4_encrypt_ksa.sv
// S-box initialisation (S[i]=i) followed by the ARC4 key schedule,
// driving the S port through registered outputs with its own en/rdy handshake.
module arc4_ksa
  import arc4_pkg::*;
#(
  parameter int KEY_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic             o_rdy,
  input  logic [KEY_W-1:0] i_key,
  output byte_t            o_addr,
  output byte_t            o_wrdata,
  output logic             o_wren,
  input  byte_t            i_rddata
);

  localparam byte_t LAST_IDX = byte_t'(SBOX_SIZE - 1);

  ksa_state_t       r_state;
  logic             r_rdy;
  logic [KEY_W-1:0] r_key;
  byte_t            r_i;
  byte_t            r_j;
  byte_t            r_si;
  logic [1:0]       r_kidx;
  byte_t            r_addr;
  byte_t            r_wrdata;
  logic             r_wren;
  byte_t            w_jn;

  assign w_jn     = r_j + i_rddata + key_byte(r_key, r_kidx);
  assign o_rdy    = r_rdy;
  assign o_addr   = r_addr;
  assign o_wrdata = r_wrdata;
  assign o_wren   = r_wren;

  // Init/KSA sequencer; the swap writes S[i] first, so i==j leaves S unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= K_IDLE;
      r_rdy    <= 1'b1;
      r_key    <= '0;
      r_i      <= 8'd0;
      r_j      <= 8'd0;
      r_si     <= 8'd0;
      r_kidx   <= 2'd0;
      r_addr   <= 8'd0;
      r_wrdata <= 8'd0;
      r_wren   <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      case (r_state)
        K_IDLE: begin
          if (i_en) begin
            r_key   <= i_key;
            r_rdy   <= 1'b0;
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_kidx  <= 2'd0;
            r_state <= K_INIT;
          end
        end
        K_INIT: begin
          r_addr   <= r_i;
          r_wrdata <= r_i;
          r_wren   <= 1'b1;
          r_i      <= r_i + 8'd1;
          if (r_i == LAST_IDX) r_state <= K_RD_I;
        end
        K_RD_I: begin
          r_addr  <= r_i;
          r_state <= K_WAIT_I;
        end
        K_WAIT_I: r_state <= K_GET_I;
        K_GET_I: begin
          r_si    <= i_rddata;
          r_j     <= w_jn;
          r_addr  <= w_jn;
          r_state <= K_WAIT_J;
        end
        K_WAIT_J: r_state <= K_GET_J;
        K_GET_J: begin
          r_addr   <= r_i;
          r_wrdata <= i_rddata;
          r_wren   <= 1'b1;
          r_state  <= K_SWAP_J;
        end
        K_SWAP_J: begin
          r_addr   <= r_j;
          r_wrdata <= r_si;
          r_wren   <= 1'b1;
          r_i      <= r_i + 8'd1;
          r_kidx   <= (r_kidx == 2'd2) ? 2'd0 : r_kidx + 2'd1;
          if (r_i == LAST_IDX) begin
            r_rdy   <= 1'b1;
            r_j     <= 8'd0;
            r_state <= K_IDLE;
          end else begin
            r_state <= K_RD_I;
          end
        end
        default: r_state <= K_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: length-prefixed PT memory -> length-prefixed CT memory.
// Define ARC4_DROP_EN to discard DROP_N keystream bytes before the message.
module arc4_encrypt
  import arc4_pkg::*;
#(
  parameter int KEY_W  = 24,
  parameter int DROP_N = 256
) (
  input logic         clk,
  input logic         rst_n,
  arc4_encrypt_if.slave bus
);

  localparam logic [15:0] DROP_LAST = 16'(DROP_N - 1);

  state_t           r_state;
  step_t            r_step;
  logic             r_rdy;
  logic [KEY_W-1:0] r_key;
  logic             r_ksa_en;
  byte_t            r_s_addr;
  byte_t            r_s_wrdata;
  logic             r_s_wren;
  byte_t            r_pt_addr;
  byte_t            r_ct_addr;
  byte_t            r_ct_wrdata;
  logic             r_ct_wren;
  byte_t            r_i;
  byte_t            r_j;
  byte_t            r_k;
  byte_t            r_len;
  byte_t            r_si;
  byte_t            r_sj;
  logic [15:0]      r_cnt;

  logic  w_ksa_rdy;
  byte_t w_ksa_addr;
  byte_t w_ksa_wrdata;
  logic  w_ksa_wren;
  logic  w_use_ksa;

  arc4_ksa #(.KEY_W(KEY_W)) u_ksa (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_en     (r_ksa_en),
    .o_rdy    (w_ksa_rdy),
    .i_key    (r_key),
    .o_addr   (w_ksa_addr),
    .o_wrdata (w_ksa_wrdata),
    .o_wren   (w_ksa_wren),
    .i_rddata (bus.s_rddata)
  );

  assign w_use_ksa     = (r_state == INIT) || (r_state == KSA);
  assign bus.s_addr    = w_use_ksa ? w_ksa_addr   : r_s_addr;
  assign bus.s_wrdata  = w_use_ksa ? w_ksa_wrdata : r_s_wrdata;
  assign bus.s_wren    = w_use_ksa ? w_ksa_wren   : r_s_wren;
  assign bus.rdy       = r_rdy;
  assign bus.pt_addr   = r_pt_addr;
  assign bus.ct_addr   = r_ct_addr;
  assign bus.ct_wrdata = r_ct_wrdata;
  assign bus.ct_wren   = r_ct_wren;

  // Top sequencer; DROP and PRGA share one keystream iteration, only PRGA emits CT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_step      <= S_ISSUE_I;
      r_rdy       <= 1'b1;
      r_key       <= '0;
      r_ksa_en    <= 1'b0;
      r_s_addr    <= 8'd0;
      r_s_wrdata  <= 8'd0;
      r_s_wren    <= 1'b0;
      r_pt_addr   <= 8'd0;
      r_ct_addr   <= 8'd0;
      r_ct_wrdata <= 8'd0;
      r_ct_wren   <= 1'b0;
      r_i         <= 8'd0;
      r_j         <= 8'd0;
      r_k         <= 8'd0;
      r_len       <= 8'd0;
      r_si        <= 8'd0;
      r_sj        <= 8'd0;
      r_cnt       <= 16'd0;
    end else begin
      r_s_wren  <= 1'b0;
      r_ct_wren <= 1'b0;
      r_ksa_en  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.en) begin
            r_key    <= bus.key;
            r_rdy    <= 1'b0;
            r_ksa_en <= 1'b1;
            r_state  <= INIT;
          end
        end
        INIT: r_state <= KSA;
        KSA: begin
          if (w_ksa_rdy) begin
            r_i   <= 8'd0;
            r_j   <= 8'd0;
            r_cnt <= 16'd0;
`ifdef ARC4_DROP_EN
            r_step  <= S_ISSUE_I;
            r_state <= DROP;
`else
            r_pt_addr <= 8'd0;
            r_step    <= S_WAIT_I;
            r_state   <= LEN;
`endif
          end
        end
        LEN: begin
          if (r_step == S_WAIT_I) begin
            r_step <= S_TAKE_I;
          end else begin
            r_len       <= bus.pt_rddata;
            r_ct_addr   <= 8'd0;
            r_ct_wrdata <= bus.pt_rddata;
            r_ct_wren   <= 1'b1;
            r_k         <= 8'd1;
            r_step      <= S_ISSUE_I;
            r_state     <= (bus.pt_rddata == 8'd0) ? DONE : PRGA;
          end
        end
        DROP, PRGA: begin
          case (r_step)
            S_ISSUE_I: begin
              r_i      <= r_i + 8'd1;
              r_s_addr <= r_i + 8'd1;
              r_step   <= S_WAIT_I;
            end
            S_WAIT_I: r_step <= S_TAKE_I;
            S_TAKE_I: begin
              r_si     <= bus.s_rddata;
              r_j      <= r_j + bus.s_rddata;
              r_s_addr <= r_j + bus.s_rddata;
              r_step   <= S_WAIT_J;
            end
            S_WAIT_J: r_step <= S_TAKE_J;
            S_TAKE_J: begin
              r_sj       <= bus.s_rddata;
              r_s_addr   <= r_i;
              r_s_wrdata <= bus.s_rddata;
              r_s_wren   <= 1'b1;
              r_step     <= S_WRITE_J;
            end
            S_WRITE_J: begin
              r_s_addr   <= r_j;
              r_s_wrdata <= r_si;
              r_s_wren   <= 1'b1;
              r_step     <= S_ISSUE_PAD;
            end
            S_ISSUE_PAD: begin
              r_s_addr  <= r_si + r_sj;
              r_pt_addr <= r_k;
              r_step    <= S_WAIT_PAD;
            end
            S_WAIT_PAD: r_step <= S_EMIT;
            S_EMIT: begin
              r_step <= S_ISSUE_I;
              if (r_state == PRGA) begin
                r_ct_addr   <= r_k;
                r_ct_wrdata <= bus.pt_rddata ^ bus.s_rddata;
                r_ct_wren   <= 1'b1;
                r_k         <= r_k + 8'd1;
                if (r_k == r_len) r_state <= DONE;
              end else if (r_cnt == DROP_LAST) begin
                r_pt_addr <= 8'd0;
                r_step    <= S_WAIT_I;
                r_state   <= LEN;
              end else begin
                r_cnt <= r_cnt + 16'd1;
              end
            end
            default: r_step <= S_ISSUE_I;
          endcase
        end
        DONE: begin
          r_rdy   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt: known-answer table, random messages against an
// array-based RC4 reference, round trip, ignored restarts and asynchronous reset mid-run.
module tb_arc4_encrypt;

  localparam int DROP_N = 256;

  typedef struct {
    logic [23:0] key;
    int          len;
    logic [7:0]  pt [16];
    logic [7:0]  ct [16];
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   ct_wr_cnt = 0;
  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ct_mem [256];
  logic [7:0] exp_ct [256];
  logic [7:0] orig   [256];
  vec_t vecs [3];

  arc4_encrypt_if #(.KEY_W(24)) bus ();

  arc4_encrypt #(.KEY_W(24), .DROP_N(DROP_N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous memories with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.pt_rddata <= pt_mem[bus.pt_addr];
    if (bus.ct_wren) begin
      ct_mem[bus.ct_addr] <= bus.ct_wrdata;
      ct_wr_cnt <= ct_wr_cnt + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Plain RC4 (optionally dropN) over a length-prefixed buffer.
  function automatic void rc4_ref(input logic [23:0] key, input logic [7:0] pt [256],
                                  output logic [7:0] ct [256]);
    int s [256];
    int kb [3];
    int i, j, t, len;
    kb[0] = int'(key[23:16]);
    kb[1] = int'(key[15:8]);
    kb[2] = int'(key[7:0]);
    for (int n = 0; n < 256; n++) begin
      s[n]  = n;
      ct[n] = 8'h00;
    end
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 0;
    j = 0;
`ifdef ARC4_DROP_EN
    for (int n = 0; n < DROP_N; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
`endif
    len   = int'(pt[0]);
    ct[0] = pt[0];
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ct[k] = pt[k] ^ 8'(s[(s[i] + s[j]) % 256]);
    end
  endfunction

  function automatic int count_bad(input logic [7:0] exp [256], input int n);
    int bad = 0;
    for (int p = 0; p <= n; p++) if (ct_mem[p] !== exp[p]) bad++;
    return bad;
  endfunction

  // Start one encryption and wait for rdy; burst pulses en and scrambles key while busy.
  task automatic run(input logic [23:0] key, input bit burst);
    bit done = 1'b0;
    @(negedge clk);
    bus.key = key;
    bus.en  = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    check("rdy_busy", int'(bus.rdy), 0);
    for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
      @(negedge clk);
      if (bus.rdy) begin
        done   = 1'b1;
        bus.en = 1'b0;
      end else if (burst && (cyc % 5 == 2)) begin
        bus.en  = 1'b1;
        bus.key = 24'($urandom);
      end else begin
        bus.en = 1'b0;
      end
    end
    bus.en = 1'b0;
    if (!done) check("run_timeout", 0, 1);
  endtask

  task automatic check_msg(input string name, input int n, input int wr_before);
    check({name, "_bytes"}, count_bad(exp_ct, n), 0);
    check({name, "_writes"}, ct_wr_cnt - wr_before, n + 1);
  endtask

  initial begin
    string       txt;
    logic [79:0] kat;
    int          wb, len;
    bit          hit;

    bus.en  = 1'b0;
    bus.key = 24'h0;
    for (int p = 0; p < 256; p++) pt_mem[p] = 8'h00;

    // Vector table: known answer, empty message, random short message.
    txt = "Plaintext";
    kat = 80'h09BBF316E8D940AF0AD3;
    vecs[0].key = 24'h4B6579;
    vecs[0].len = 9;
    vecs[1].key = 24'h000018;
    vecs[1].len = 0;
    vecs[2].key = 24'($urandom);
    vecs[2].len = 12;
    for (int v = 0; v < 3; v++)
      for (int p = 0; p < 16; p++) begin
        vecs[v].pt[p] = 8'h00;
        vecs[v].ct[p] = 8'h00;
      end
    for (int p = 0; p < 9; p++) vecs[0].pt[p+1] = txt[p];
    for (int p = 0; p < 10; p++) vecs[0].ct[p] = kat[79-8*p -: 8];
    for (int p = 1; p <= 12; p++) vecs[2].pt[p] = 8'($urandom);
    for (int v = 0; v < 3; v++) vecs[v].pt[0] = 8'(vecs[v].len);
`ifdef ARC4_DROP_EN
    for (int v = 0; v < 3; v += 2) begin
`else
    for (int v = 2; v < 3; v++) begin
`endif
      for (int p = 0; p < 256; p++) pt_mem[p] = (p < 16) ? vecs[v].pt[p] : 8'h00;
      rc4_ref(vecs[v].key, pt_mem, exp_ct);
      for (int p = 0; p < 16; p++) vecs[v].ct[p] = exp_ct[p];
    end

    // Reset values, during and just after reset.
    repeat (3) @(negedge clk);
    check("rst_rdy", int'(bus.rdy), 1);
    check("rst_s_wren", int'(bus.s_wren), 0);
    check("rst_ct_wren", int'(bus.ct_wren), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_rdy", int'(bus.rdy), 1);
    check("idle_addrs", int'({bus.s_addr, bus.pt_addr, bus.ct_addr, bus.s_wrdata, bus.ct_wrdata}), 0);

    for (int v = 0; v < 3; v++) begin
      for (int p = 0; p < 256; p++) begin
        pt_mem[p] = (p < 16) ? vecs[v].pt[p] : 8'h00;
        exp_ct[p] = (p < 16) ? vecs[v].ct[p] : 8'h00;
      end
      wb = ct_wr_cnt;
      run(vecs[v].key, 1'b0);
      check_msg($sformatf("vec%0d", v), vecs[v].len, wb);
      check($sformatf("vec%0d_rdy", v), int'(bus.rdy), 1);
    end

    // Random keys and lengths against the reference model.
    for (int r = 0; r < 3; r++) begin
      logic [23:0] key = 24'($urandom);
      len = $urandom_range(1, 40);
      pt_mem[0] = 8'(len);
      for (int p = 1; p < 256; p++) pt_mem[p] = 8'($urandom);
      rc4_ref(key, pt_mem, exp_ct);
      wb = ct_wr_cnt;
      run(key, 1'b0);
      check_msg($sformatf("rand%0d", r), len, wb);
    end

    // Round trip over a full 255-byte message.
    pt_mem[0] = 8'd255;
    for (int p = 1; p < 256; p++) pt_mem[p] = 8'($urandom);
    for (int p = 0; p < 256; p++) orig[p] = pt_mem[p];
    rc4_ref(24'h1A2B3C, pt_mem, exp_ct);
    wb = ct_wr_cnt;
    run(24'h1A2B3C, 1'b0);
    check_msg("rt_enc", 255, wb);
    for (int p = 0; p < 256; p++) begin
      pt_mem[p] = ct_mem[p];
      exp_ct[p] = orig[p];
    end
    wb = ct_wr_cnt;
    run(24'h1A2B3C, 1'b0);
    check_msg("rt_dec", 255, wb);

    // Extra en pulses (with a changing key) while busy must be ignored.
    pt_mem[0] = 8'd20;
    for (int p = 1; p < 256; p++) pt_mem[p] = 8'($urandom);
    rc4_ref(24'hC0FFEE, pt_mem, exp_ct);
    wb = ct_wr_cnt;
    run(24'hC0FFEE, 1'b1);
    repeat (30) @(negedge clk);
    check_msg("burst", 20, wb);
    check("burst_idle_rdy", int'(bus.rdy), 1);

    // Asynchronous reset in the middle of PRGA, then a clean restart.
    pt_mem[0] = 8'd60;
    for (int p = 1; p < 256; p++) pt_mem[p] = 8'($urandom);
    rc4_ref(24'h5A5A5A, pt_mem, exp_ct);
    wb = ct_wr_cnt;
    @(negedge clk);
    bus.key = 24'h5A5A5A;
    bus.en  = 1'b1;
    @(negedge clk);
    bus.en = 1'b0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 20000 && !hit; cyc++) begin
      @(negedge clk);
      if (ct_wr_cnt - wb >= 5) hit = 1'b1;
    end
    check("reach_prga", int'(hit), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rdy", int'(bus.rdy), 1);
    check("async_s_wren", int'(bus.s_wren), 0);
    check("async_ct_wren", int'(bus.ct_wren), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb = ct_wr_cnt;
    run(24'h5A5A5A, 1'b0);
    check_msg("restart", 60, wb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
